bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 16-bit source multiplexer (9 channels, channel 8 = instruction channel). Takes per-channel bus requests, grants exactly one owner at a time, and drives the mux 4-bit select code. Enforces a maximum tenure so no source can starve the others. An optional fixed priority lets the instruction channel pre-empt arbitration.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_rr_pick.sv | 36 +++
 rtl/bus_arbiter.sv | 120 ++++++++++++
 tb/tb_bus_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the source-multiplexer bus arbiter.
//   SEL_IDLE     : select code meaning "no owner" (mux drives 0)
//   NUM_SRC_DEF  : default number of requesting channels
//   INSTR_CH     : index of the instruction channel in the default build
//   state_e      : arbiter FSM states
package bus_arbiter_pkg;

  localparam logic [3:0] SEL_IDLE    = 4'hF;
  localparam int         NUM_SRC_DEF = 9;
  localparam int         INSTR_CH    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotating-priority encoder.
// Searches req_i starting at last_i+1 and wrapping through last_i itself,
// returning the first requesting channel.
//   req_i    : per-channel request vector
//   last_i   : index of the most recently served channel
//   winner_o : index of the selected channel (0 when nothing found)
//   found_o  : high when at least one request is set
module rr_pick #(
  parameter int NUM_SRC = 9,
  parameter int SEL_W   = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic [SEL_W-1:0]   winner_o,
  output logic               found_o
);

  int unsigned         idx;
  logic [NUM_SRC-1:0]  shifted;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    shifted  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx     = (int'(last_i) + i) % NUM_SRC;
      shifted = req_i >> idx;
      if (!found_o && shifted[0]) begin
        found_o  = 1'b1;
        winner_o = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit source multiplexer.
// Grants one owner at a time, limits each tenure to MAX_HOLD cycles and
// optionally lets the top channel win every arbitration (never pre-empting
// a running tenure).
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   req       : per-channel level request
//   select    : registered mux select code, SEL_IDLE when idle
//   grant     : registered one-hot grant, zero when idle
//   bus_valid : |grant
//   hold_cnt  : cycles already spent by the current owner
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int SEL_W      = 4,
  parameter int MAX_HOLD   = 8,
  parameter int INSTR_PRIO = 1,
  localparam int HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  output logic [SEL_W-1:0]   select,
  output logic [NUM_SRC-1:0] grant,
  output logic               bus_valid,
  output logic [HC_W-1:0]    hold_cnt
);

  localparam logic [SEL_W-1:0]   SEL_NONE = SEL_W'(SEL_IDLE);
  localparam logic [SEL_W-1:0]   LAST_RST = SEL_W'(NUM_SRC - 1);
  localparam logic [HC_W-1:0]    HOLD_END = HC_W'(MAX_HOLD - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

  state_e               state_q,  state_d;
  logic [NUM_SRC-1:0]   grant_q,  grant_d;
  logic [SEL_W-1:0]     select_q, select_d;
  logic [HC_W-1:0]      hold_q,   hold_d;
  logic [SEL_W-1:0]     last_q,   last_d;

  logic [SEL_W-1:0]     rr_win;
  logic                 rr_found;
  logic [SEL_W-1:0]     win;
  logic                 owner_req;
  logic                 rearb;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (rr_win),
    .found_o  (rr_found)
  );

  // The instruction channel overrides the rotation; it still implies found.
  assign win = ((INSTR_PRIO != 0) && req[NUM_SRC-1]) ? LAST_RST : rr_win;

  // The owner's own request, picked out via the one-hot grant.
  assign owner_req = |(req & grant_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    hold_d   = hold_q;
    last_d   = last_q;
    rearb    = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      OWN: begin
        // Release and timeout both hand over in the same edge.
        if (!owner_req || (hold_q == HOLD_END)) begin
          rearb = 1'b1;
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      hold_d = '0;
      if (rr_found) begin
        state_d  = OWN;
        grant_d  = ONE_HOT0 << win;
        select_d = win;
        last_d   = win;
      end else begin
        state_d  = IDLE;
        grant_d  = '0;
        select_d = SEL_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      select_q <= SEL_NONE;
      hold_q   <= '0;
      last_q   <= LAST_RST;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
    end
  end

  assign select    = select_q;
  assign grant     = grant_q;
  assign bus_valid = |grant_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int N  = 9;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;

  logic [3:0]   select_a, select_b;
  logic [N-1:0] grant_a,  grant_b;
  logic         valid_a,  valid_b;
  logic [2:0]   hold_a,   hold_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, [0] = instruction priority on, [1] = off
  int m_owner[2];
  int m_cnt[2];
  int m_last[2];

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_SRC(N), .SEL_W(4), .MAX_HOLD(MH), .INSTR_PRIO(1)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .select(select_a), .grant(grant_a), .bus_valid(valid_a), .hold_cnt(hold_a)
  );

  bus_arbiter #(.NUM_SRC(N), .SEL_W(4), .MAX_HOLD(MH), .INSTR_PRIO(0)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .select(select_b), .grant(grant_b), .bus_valid(valid_b), .hold_cnt(hold_b)
  );

  function automatic int pick(input logic [N-1:0] r, input int last, input bit prio);
    if (prio && r[N-1]) return N - 1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input int m, input logic [N-1:0] r, input logic rs);
    int w;
    if (rs) begin
      m_owner[m] = -1; m_cnt[m] = 0; m_last[m] = N - 1;
    end else if (m_owner[m] >= 0 && r[m_owner[m]] && m_cnt[m] < MH - 1) begin
      m_cnt[m] = m_cnt[m] + 1;
    end else begin
      w = pick(r, m_last[m], (m == 0));
      m_cnt[m] = 0;
      m_owner[m] = w;
      if (w >= 0) m_last[m] = w;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_models();
    logic [31:0] eg, es;
    for (int m = 0; m < 2; m++) begin
      eg = (m_owner[m] < 0) ? 32'h0 : (32'h1 << m_owner[m]);
      es = (m_owner[m] < 0) ? 32'hF : 32'(m_owner[m]);
      if (m == 0) begin
        chk("grant_p1",  32'(grant_a),  eg);
        chk("select_p1", 32'(select_a), es);
        chk("valid_p1",  32'(valid_a),  32'(eg != 0));
        chk("hold_p1",   32'(hold_a),   32'(m_cnt[m]));
      end else begin
        chk("grant_p0",  32'(grant_b),  eg);
        chk("select_p0", 32'(select_b), es);
        chk("valid_p0",  32'(valid_b),  32'(eg != 0));
        chk("hold_p0",   32'(hold_b),   32'(m_cnt[m]));
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic step(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(0, r, rs);
    model_edge(1, r, rs);
    #1;
    check_models();
  endtask

  initial begin
    logic [N-1:0] r;
    m_owner = '{-1, -1}; m_cnt = '{0, 0}; m_last = '{N-1, N-1};

    // Reset and idle
    step('0, 1'b1);
    chk("rst_select", 32'(select_a), 32'hF);
    chk("rst_grant",  32'(grant_a),  32'h0);
    for (int i = 0; i < 5; i++) step('0, 1'b0);
    chk("idle_valid", 32'(valid_a), 32'h0);

    // Reset mid-tenure
    step(9'h008, 1'b0);
    step(9'h008, 1'b0);
    chk("pre_rst_grant", 32'(grant_a), 32'h008);
    step(9'h008, 1'b1);
    chk("rst_mid_grant", 32'(grant_a), 32'h0);

    // Single channel, short tenure
    for (int i = 0; i < 3; i++) begin
      step(9'h001, 1'b0);
      chk("ch0_grant", 32'(grant_a), 32'h001);
      chk("ch0_hold",  32'(hold_a),  32'(i));
    end
    step('0, 1'b0);
    chk("ch0_release", 32'(select_a), 32'hF);

    // Three channels rotating on timeout
    step('0, 1'b1);
    for (int i = 0; i < 3 * MH * 2; i++) begin
      step(9'h00E, 1'b0);
      chk("rot_owner", 32'(grant_a), 32'h1 << (1 + (i / MH) % 3));
    end

    // Lone channel re-granted after timeout
    step('0, 1'b1);
    for (int i = 0; i < 2 * MH + 3; i++) begin
      step(9'h020, 1'b0);
      chk("solo_grant", 32'(grant_a), 32'h020);
      chk("solo_hold",  32'(hold_a),  32'(i % MH));
    end

    // Instruction channel priority versus plain rotation
    step('0, 1'b1);
    step(9'h004, 1'b0);
    step(9'h114, 1'b0);
    chk("noprempt_p1", 32'(grant_a), 32'h004);
    step(9'h110, 1'b0);
    chk("instr_win_p1", 32'(grant_a),  32'h100);
    chk("instr_sel_p1", 32'(select_a), 32'h8);
    chk("rr_win_p0",    32'(grant_b),  32'h010);
    step(9'h010, 1'b0);
    chk("after_instr_p1", 32'(grant_a), 32'h010);
    step(9'h100, 1'b0);
    chk("then_instr_p0", 32'(grant_b), 32'h100);

    // Randomised traffic with occasional resets
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom & $urandom);
      step(r, ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
